// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_display_scanner
//  Purpose  : Captures a nine-digit BCD value on a load strobe and
//             time-multiplexes it onto a 9-digit 7-segment display, with
//             optional leading-zero blanking and invalid-digit detection.
//
//  Ports    :
//    Clk        in   1   system clock, rising edge
//    Reset_n    in   1   asynchronous active-low reset
//    load       in   1   capture strobe for BCD0..BCD8 and blank_lz
//    blank_lz   in   1   leading-zero blanking enable (sampled with load)
//    BCD0..BCD8 in   4   digit values, BCD0 = ones
//    seg        out  7   {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//    an         out  9   one-hot digit enable, polarity per AN_ACTIVE_LOW
//    digit_sel  out  4   index of the digit currently driven (0..8)
//    err        out  1   captured set contains a digit > 9
//
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int PRESCALE       = 50000,  // clocks per digit slot, >= 2
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       load,
    input  logic       blank_lz,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic [3:0] BCD4,
    input  logic [3:0] BCD5,
    input  logic [3:0] BCD6,
    input  logic [3:0] BCD7,
    input  logic [3:0] BCD8,
    output logic [6:0] seg,
    output logic [8:0] an,
    output logic [3:0] digit_sel,
    output logic       err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_PRESC_W = $clog2(PRESCALE);
    localparam logic [3:0] c_LAST    = 4'd8;
    // "Dark" levels in the configured output polarity.
    localparam logic [6:0] c_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [8:0] c_AN_OFF  = AN_ACTIVE_LOW  ? 9'h1FF : 9'h000;

    // ------------------------------------------------------------------------
    // Active-high segment decode; codes A..F show a centre dash.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_seg7(input logic [3:0] i_d);
        logic [6:0] v_s;
        case (i_d)
            4'd0:    v_s = 7'h3F;
            4'd1:    v_s = 7'h06;
            4'd2:    v_s = 7'h5B;
            4'd3:    v_s = 7'h4F;
            4'd4:    v_s = 7'h66;
            4'd5:    v_s = 7'h6D;
            4'd6:    v_s = 7'h7D;
            4'd7:    v_s = 7'h07;
            4'd8:    v_s = 7'h7F;
            4'd9:    v_s = 7'h6F;
            default: v_s = 7'h40;
        endcase
        return v_s;
    endfunction

    // ------------------------------------------------------------------------
    // Input bundling
    // ------------------------------------------------------------------------
    logic [8:0][3:0] w_bcd;
    assign w_bcd = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};

    // ------------------------------------------------------------------------
    // Capture-side combinational logic
    // ------------------------------------------------------------------------
    logic [8:0] w_load_mask;
    logic       w_load_err;

    // Digit k (k >= 1) is a leading zero when it and every more significant
    // digit are zero. Codes > 9 are nonzero, so they stop the blanking run.
    always_comb begin
        logic v_tail_zero;
        w_load_mask = '0;
        v_tail_zero = 1'b1;
        for (int k = 8; k >= 1; k--) begin
            v_tail_zero    = v_tail_zero & (w_bcd[k] == 4'd0);
            w_load_mask[k] = blank_lz & v_tail_zero;
        end
    end

    always_comb begin
        w_load_err = 1'b0;
        for (int k = 0; k < 9; k++) begin
            w_load_err = w_load_err | (w_bcd[k] > 4'd9);
        end
    end

    // ------------------------------------------------------------------------
    // Shadow registers: digits, blank mask and error flag
    // ------------------------------------------------------------------------
    logic [8:0][3:0] r_digit;
    logic [8:0]      r_blank;
    logic            r_err;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_digit <= '0;
            r_blank <= '0;
            r_err   <= 1'b0;
        end else if (load) begin
            r_digit <= w_bcd;
            r_blank <= w_load_mask;
            r_err   <= w_load_err;
        end
    end

    // ------------------------------------------------------------------------
    // Slot prescaler
    // ------------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tc;

    assign w_tc = (r_presc == c_PRESC_W'(PRESCALE - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_presc <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Next-slot drive values. These read the shadow registers as they stand
    // before the TC edge, so a load on that same edge only takes effect from
    // the following slot boundary.
    // ------------------------------------------------------------------------
    logic [3:0] r_sel;
    logic [3:0] w_next_sel;
    logic       w_slot_blank;
    logic [6:0] w_seg_ah;
    logic [8:0] w_an_ah;
    logic [6:0] w_seg_next;
    logic [8:0] w_an_next;

    // Reset value 8 makes the first boundary land on digit 0.
    assign w_next_sel   = (r_sel >= c_LAST) ? 4'd0 : (r_sel + 4'd1);
    assign w_slot_blank = r_blank[w_next_sel];

    assign w_seg_ah   = w_slot_blank ? 7'h00 : f_seg7(r_digit[w_next_sel]);
    assign w_an_ah    = w_slot_blank ? 9'h000 : (9'h001 << w_next_sel);
    assign w_seg_next = SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
    assign w_an_next  = AN_ACTIVE_LOW  ? ~w_an_ah  : w_an_ah;

    // ------------------------------------------------------------------------
    // Display output registers. Polarity is applied before the flops so the
    // pins come straight from registers and only ever change at TC.
    // ------------------------------------------------------------------------
    logic [6:0] r_seg;
    logic [8:0] r_an;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sel <= c_LAST;
            r_seg <= c_SEG_OFF;
            r_an  <= c_AN_OFF;
        end else if (w_tc) begin
            r_sel <= w_next_sel;
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign digit_sel = r_sel;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bcd_display_scanner
//  Purpose  : Scoreboard bench for bcd_display_scanner (PRESCALE = 4,
//             default polarities). The driver computes per-cycle expected
//             display/err state from a digit-level model; a monitor pops
//             and compares one entry after every rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int P = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] bcd [9];
    logic [6:0] seg;
    logic [8:0] an;
    logic [3:0] digit_sel;
    logic       err;

    always #5 Clk = ~Clk;

    bcd_display_scanner #(
        .PRESCALE      (P),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (load),
        .blank_lz (blank_lz),
        .BCD0     (bcd[0]),
        .BCD1     (bcd[1]),
        .BCD2     (bcd[2]),
        .BCD3     (bcd[3]),
        .BCD4     (bcd[4]),
        .BCD5     (bcd[5]),
        .BCD6     (bcd[6]),
        .BCD7     (bcd[7]),
        .BCD8     (bcd[8]),
        .seg      (seg),
        .an       (an),
        .digit_sel(digit_sel),
        .err      (err)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [6:0] seg;
        logic [8:0] an;
        logic [3:0] sel;
        logic       err;
    } exp_t;

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                7'h40, 7'h40, 7'h40, 7'h40};
    int   m_dig [9];
    bit   m_blz;
    bit   m_err;
    exp_t m_cur;
    int   cyc;
    exp_t exp_q [$];
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t reset_exp();
        exp_t e;
        e.seg = 7'h7F;
        e.an  = 9'h1FF;
        e.sel = 4'd8;
        e.err = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_dig[k] = 0;
        m_blz = 1'b0;
        m_err = 1'b0;
        m_cur = reset_exp();
        cyc   = 0;
        exp_q.delete();
    endtask

    // What slot s shows, from the digit rules: dark if it is a leading zero.
    function automatic exp_t slot_exp(int s);
        exp_t       e;
        bit         blank;
        logic [8:0] onehot;
        logic [6:0] code;
        blank = m_blz && (s != 0);
        for (int j = s; j < 9; j++) if (m_dig[j] != 0) blank = 1'b0;
        code   = segtab[m_dig[s]];
        onehot = 9'h001 << s;
        e.sel  = 4'(s);
        e.seg  = blank ? 7'h7F : ~code;
        e.an   = blank ? 9'h1FF : ~onehot;
        e.err  = 1'b0;
        return e;
    endfunction

    // Drive one cycle of inputs, push the expected post-edge state, wait.
    task automatic step(input bit ld, input logic [35:0] d, input bit blz);
        exp_t e;
        load     = ld;
        blank_lz = blz;
        for (int k = 0; k < 9; k++) bcd[k] = d[4*k +: 4];
        cyc++;
        if (cyc % P == 0) m_cur = slot_exp((cyc / P - 1) % 9);
        if (ld) begin
            m_blz = blz;
            m_err = 1'b0;
            for (int k = 0; k < 9; k++) begin
                m_dig[k] = int'(d[4*k +: 4]);
                if (m_dig[k] > 9) m_err = 1'b1;
            end
        end
        e     = m_cur;
        e.err = m_err;
        exp_q.push_back(e);
        @(negedge Clk);
    endtask

    function automatic logic [35:0] pack_dec(longint unsigned v);
        logic [35:0] r;
        for (int k = 0; k < 9; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [35:0] rand36();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[35:0];
    endfunction

    task automatic idle(int n);
        repeat (n) step(1'b0, rand36(), 1'($urandom_range(0, 1)));
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: one scoreboard entry per rising edge
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({seg, an, digit_sel} !== {e.seg, e.an, e.sel}) begin
                        errors++;
                        $display("FAIL display: got sel=%0d seg=%h an=%h expected sel=%0d seg=%h an=%h at %0t",
                                 digit_sel, seg, an, e.sel, e.seg, e.an, $time);
                    end
                    chk("err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [35:0]     d;
        longint unsigned v;
        for (int k = 0; k < 9; k++) bcd[k] = 4'd0;

        // Reset held: static reset values
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_an", 32'(an), 32'h1FF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_sel", 32'(digit_sel), 32'd8);
        chk("reset_err", 32'(err), 32'd0);

        // Release; first slot lights digit 0 on the 4th edge
        model_reset();
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(8);

        // Full scan of 650345768 without blanking
        step(1'b1, pack_dec(64'd650345768), 1'b0);
        idle(40);
        // 1234593 with blanking: slots 7,8 dark
        step(1'b1, pack_dec(64'd1234593), 1'b1);
        idle(40);
        // All zeros with blanking: only slot 0 lit
        step(1'b1, pack_dec(64'd0), 1'b1);
        idle(40);
        // Invalid digit in position 3, then a clean load
        d = pack_dec(64'd987654321);
        d[15:12] = 4'hC;
        step(1'b1, d, 1'b0);
        idle(40);
        step(1'b1, pack_dec(64'd111111511), 1'b0);
        idle(3);

        // Load exactly on the edge that enters slot 2 (BCD2 5 -> 9)
        while (!(((cyc + 1) % P == 0) && (((cyc + 1) / P - 1) % 9 == 2))) idle(1);
        step(1'b1, pack_dec(64'd111111911), 1'b0);
        idle(40);

        // Random loads
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                v = longint'($urandom_range(0, 999999999));
                for (int r = $urandom_range(0, 8); r > 0; r--) v = v / 10;
                d = pack_dec(v);
                if ($urandom_range(0, 3) == 0) d[4*$urandom_range(0, 8) +: 4] = 4'(10 + $urandom_range(0, 5));
                step(1'b1, d, 1'($urandom_range(0, 1)));
            end else begin
                idle(1);
            end
        end

        // Mid-slot asynchronous reset
        mon_en = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'h1FF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_sel", 32'(digit_sel), 32'd8);
        chk("async_err", 32'(err), 32'd0);
        @(negedge Clk);
        model_reset();
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(12);
        step(1'b1, pack_dec(64'd305), 1'b1);
        idle(40);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
